// File: rtl/l1_dcache_pkg.sv
// rtl/l1_dcache_pkg.sv - shared types and geometry for the L1 data cache
package l1_dcache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 23;
  localparam int SET_W  = 4;
  localparam int WORD_W = 3;
  localparam int NSETS  = 1 << SET_W;
  localparam int NWORDS = 1 << WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [SET_W-1:0]  set;
    logic [WORD_W-1:0] word;
    logic [1:0]        byte_sel;
  } addr_t;

  function automatic logic [ADDR_W-1:0] line_word_addr(
    input logic [TAG_W-1:0]  tag,
    input logic [SET_W-1:0]  set,
    input logic [WORD_W-1:0] word
  );
    return {tag, set, word, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - valid/dirty/tag/data arrays of the L1 data cache
module dcache_line_store
  import l1_dcache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SET_W-1:0]  rd_set_i,
  input  logic [WORD_W-1:0] rd_word_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [SET_W-1:0]  wr_set_i,
  input  logic [WORD_W-1:0] wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              inst_en_i,
  input  logic [SET_W-1:0]  inst_set_i,
  input  logic [TAG_W-1:0]  inst_tag_i,
  input  logic              dirty_set_i,
  input  logic              dirty_clr_i,
  input  logic [SET_W-1:0]  dirty_idx_i
);

  logic [NSETS-1:0]  valid_q;
  logic [NSETS-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [DATA_W-1:0] data_q [NSETS][NWORDS];

  assign rd_valid_o = valid_q[rd_set_i];
  assign rd_dirty_o = dirty_q[rd_set_i];
  assign rd_tag_o   = tag_q[rd_set_i];
  assign rd_data_o  = data_q[rd_set_i][rd_word_i];

  // Only the state bits are reset; tag and data contents survive reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (inst_en_i)   valid_q[inst_set_i]  <= 1'b1;
      if (dirty_set_i) dirty_q[dirty_idx_i] <= 1'b1;
      if (dirty_clr_i) dirty_q[dirty_idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i)   data_q[wr_set_i][wr_word_i] <= wr_data_i;
    if (inst_en_i) tag_q[inst_set_i]           <= inst_tag_i;
  end

endmodule

// File: rtl/l1_dcache.sv
// rtl/l1_dcache.sv - direct-mapped write-back write-allocate L1 data cache
module l1_dcache
  import l1_dcache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rreq,
  input  logic              wreq,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  addr_t             req;
  state_e            state_q;
  logic [WORD_W-1:0] cnt_q;
  logic [TAG_W-1:0]  ltag_q;
  logic [SET_W-1:0]  lset_q;

  logic              idle, hit, req_any, last_ack, wr_hit;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic [SET_W-1:0]  port_set;
  logic [WORD_W-1:0] port_word;
  logic              unused_byte;

  assign req         = addr_t'(addr);
  assign unused_byte = ^req.byte_sel;
  assign idle        = (state_q == IDLE);
  assign req_any     = rreq | wreq;
  assign last_ack    = mem_ack && (cnt_q == 3'd7);

  // One shared store port: the request indexes it in IDLE, the latched line otherwise.
  assign port_set  = idle ? req.set  : lset_q;
  assign port_word = idle ? req.word : cnt_q;

  assign hit    = rd_valid && (rd_tag == req.tag);
  assign wr_hit = idle && wreq && hit;
  assign miss   = req_any && (!idle || !hit);
  assign rdata  = (rreq && hit && idle) ? rd_data : '0;

  assign mem_req   = (state_q == WB) || (state_q == FILL);
  assign mem_we    = (state_q == WB);
  assign mem_wdata = (state_q == WB) ? rd_data : '0;

  always_comb begin
    mem_addr = '0;
    case (state_q)
      WB:      mem_addr = line_word_addr(rd_tag, lset_q, cnt_q);
      FILL:    mem_addr = line_word_addr(ltag_q, lset_q, cnt_q);
      default: mem_addr = '0;
    endcase
  end

  dcache_line_store u_store (
    .clk         (clk),
    .reset       (reset),
    .rd_set_i    (port_set),
    .rd_word_i   (port_word),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (wr_hit || ((state_q == FILL) && mem_ack)),
    .wr_set_i    (port_set),
    .wr_word_i   (port_word),
    .wr_data_i   (idle ? wdata : mem_rdata),
    .inst_en_i   ((state_q == FILL) && last_ack),
    .inst_set_i  (lset_q),
    .inst_tag_i  (ltag_q),
    .dirty_set_i (wr_hit),
    .dirty_clr_i ((state_q == WB) && last_ack),
    .dirty_idx_i (port_set)
  );

  // cnt wraps 7->0 on the final ack of each phase, so WB hands FILL a zeroed counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ltag_q  <= '0;
      lset_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any && !hit) begin
            ltag_q  <= req.tag;
            lset_q  <= req.set;
            cnt_q   <= '0;
            state_q <= (rd_valid && rd_dirty) ? WB : FILL;
          end
        end
        WB: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// tb/tb_l1_dcache.sv - self-checking bench for l1_dcache against a memory-level reference model
module tb_l1_dcache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rreq = 1'b0;
  logic        wreq = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  l1_dcache dut (
    .clk       (clk),
    .reset     (reset),
    .rreq      (rreq),
    .wreq      (wreq),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int lat = 0;
  int wait_cnt = 0;
  int n_ack = 0;

  // bmem: backing store as seen on the bus; cmem: CPU-visible overrides not yet written back
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] cmem [logic [31:0]];

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;
  xfer_t log_q[$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a >> 2) - 32'h30;
  endfunction

  function automatic logic [31:0] bval(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] cval(input logic [31:0] a);
    return cmem.exists(a) ? cmem[a] : bval(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus responder: decides ack at the falling edge, the DUT consumes it at the next rising edge.
  always @(negedge clk) begin
    if (!reset || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= lat) begin
      mem_ack  = 1'b1;
      wait_cnt = 0;
      n_ack++;
      if (mem_we) begin
        check("wb_data", mem_wdata, cval(mem_addr));
        bmem[mem_addr] = mem_wdata;
      end else begin
        mem_rdata = bval(mem_addr);
      end
      log_q.push_back('{we: mem_we, a: mem_addr, d: mem_wdata});
    end else begin
      mem_ack = 1'b0;
      wait_cnt++;
    end
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int mcyc, output logic [31:0] rd);
    int cyc;
    @(posedge clk); #1;
    rreq = !wr; wreq = wr; addr = a; wdata = d;
    cyc = 0; mcyc = 0; rd = '0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (!miss) break;
      mcyc++;
      if (cyc > 500) begin
        check("timeout", {31'd0, miss}, 32'd0);
        break;
      end
    end
    rd = rdata;
    if (!wr) check("read_data", rdata, cval(a));
    else cmem[a] = d;
    @(posedge clk); #1;
    rreq = 1'b0; wreq = 1'b0;
  endtask

  initial begin
    int mc;
    logic [31:0] rd;

    #2;
    check("rst_miss", {31'd0, miss}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    #10 reset = 1'b1;

    // Cold read: clean refill of set 8
    lat = 0; log_q.delete();
    access(1'b0, 32'h0000_0100, 32'd0, mc, rd);
    check("cold_rdata", rd, 32'h10);
    check("cold_miss_cycles", mc, 32'd9);
    check("cold_xfers", log_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("cold_we", {31'd0, log_q[i].we}, 32'd0);
      check("cold_addr", log_q[i].a, 32'h100 + 32'(4 * i));
    end
    access(1'b0, 32'h0000_0104, 32'd0, mc, rd);
    check("hit_rdata", rd, 32'h11);
    check("hit_miss_cycles", mc, 32'd0);

    // Write hit: no bus traffic
    log_q.delete();
    access(1'b1, 32'h0000_0108, 32'h3FF, mc, rd);
    check("whit_miss_cycles", mc, 32'd0);
    check("whit_xfers", log_q.size(), 32'd0);
    access(1'b0, 32'h0000_0108, 32'd0, mc, rd);
    check("whit_readback", rd, 32'h3FF);

    // Dirty conflict miss: writeback then refill
    log_q.delete();
    access(1'b0, 32'h0000_0300, 32'd0, mc, rd);
    check("dirty_miss_cycles", mc, 32'd17);
    check("dirty_rdata", rd, 32'h90);
    check("dirty_xfers", log_q.size(), 32'd16);
    for (int i = 0; i < 8 && i + 8 < log_q.size(); i++) begin
      check("wb_we", {31'd0, log_q[i].we}, 32'd1);
      check("wb_addr", log_q[i].a, 32'h100 + 32'(4 * i));
      check("fill_we", {31'd0, log_q[i + 8].we}, 32'd0);
      check("fill_addr", log_q[i + 8].a, 32'h300 + 32'(4 * i));
    end
    if (log_q.size() > 2) check("wb_word2", log_q[2].d, 32'h3FF);

    // Write miss into clean set 2
    log_q.delete();
    access(1'b1, 32'h0000_0440, 32'h55, mc, rd);
    check("wmiss_miss_cycles", mc, 32'd9);
    check("wmiss_xfers", log_q.size(), 32'd8);
    if (log_q.size() > 0) check("wmiss_first_addr", log_q[0].a, 32'h440);
    access(1'b0, 32'h0000_0440, 32'd0, mc, rd);
    check("wmiss_readback", rd, 32'h55);

    // Reset after the 3rd refill ack of a clean miss
    log_q.delete();
    n_ack = 0;
    @(posedge clk); #1;
    rreq = 1'b1; addr = 32'h0000_0500;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (n_ack >= 3) break;
    end
    check("rst_mid_acks", n_ack, 32'd3);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    rreq = 1'b0;
    cmem.delete();
    #2 reset = 1'b1;
    log_q.delete();
    access(1'b0, 32'h0000_0500, 32'd0, mc, rd);
    check("rst_refill_cycles", mc, 32'd9);
    check("rst_refill_xfers", log_q.size(), 32'd8);
    if (log_q.size() > 0) check("rst_refill_word0", log_q[0].a, 32'h500);
    access(1'b0, 32'h0000_0440, 32'd0, mc, rd);
    check("rst_lost_dirty", rd, dflt(32'h440));

    // Random mix against the reference memory
    for (int n = 0; n < 250; n++) begin
      bit          wr;
      logic [31:0] a;
      lat = $urandom_range(0, 2);
      wr = ($urandom_range(0, 9) < 4);
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5)
          | (32'($urandom_range(0, 7)) << 2);
      access(wr, a, $urandom, mc, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-back, write-allocate L1 data cache. It sits between the CPU data port and the shared memory bus. It is the responder side of the `rreq`/`wreq`/`miss` request protocol driven by the CPU and the memory-system stimulus benches. On the far side it acts as initiator of a word-serial `mem_req`/`mem_ack` bus for line refill and writeback.

## Interface
- `ADDR_W`, 32, byte-address width; split is tag[31:9], set[8:5], word[4:2], byte[1:0]
- `SET_W`, 4, 16 sets
- `WORD_W`, 3, 8 words per line
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-low
- `rreq` input 1: read request, held until `miss` low
- `wreq` input 1: write request, held until `miss` low; wins if `rreq` is also high
- `addr` input 32: word-aligned request address
- `wdata` input 32: write data
- `rdata` output 32: read data, valid when `rreq && !miss`
- `miss` output 1: request not yet serviced
- `mem_req` output 1: bus word-transfer request
- `mem_we` output 1: 1 for writeback, 0 for refill
- `mem_addr` output 32: word address of the current bus transfer
- `mem_wdata` output 32: writeback data
- `mem_rdata` input 32: refill data, sampled with `mem_ack`
- `mem_ack` input 1: one-cycle pulse that completes one word transfer

## Operation
- Per set: `valid`, `dirty`, a 23-bit tag, and 8×32 data.
- `hit = valid[set] && tag[set]==addr.tag`.
- `miss = (rreq|wreq) && (state!=IDLE || !hit)`. This is combinational.
- `rdata = (rreq && hit && state==IDLE) ? data[set][word] : 0`.
- Write hit: at the clock edge, write `data[set][word]<=wdata` and set `dirty[set]<=1`. There is no bus traffic.
- Miss in IDLE: latch `tag` and `set` into `ltag`/`lset`, then clear `cnt`.
  - If the victim is valid and dirty, go to WB.
  - Otherwise go to FILL.
- WB state:
  - `mem_req=1`, `mem_we=1`.
  - `mem_addr={tag[lset],lset,cnt,2'b0}`, `mem_wdata=data[lset][cnt]`.
  - On `mem_ack`, increment `cnt`. When `cnt==7` and `mem_ack`: clear `cnt`, clear `dirty`, go to FILL.
- FILL state:
  - `mem_req=1`, `mem_we=0`, `mem_addr={ltag,lset,cnt,2'b0}`.
  - On `mem_ack`, write `data[lset][cnt]<=mem_rdata` and increment `cnt`.
  - When `cnt==7` and `mem_ack`: set `tag[lset]<=ltag` and `valid<=1`, then go to IDLE.
- A write miss completes after the refill. In IDLE the request now hits, and the write is performed as a write hit.
- States: IDLE, WB, FILL. `cnt` is 3 bits and wraps 7→0 only on the final ack.
- Boundary cases:
  - Request dropped or changed mid-miss: the transfer still completes using `ltag`/`lset`, and the line is installed.
  - `mem_ack` while `mem_req` is low: ignored.
  - Reset asserted mid-transfer: the state goes to IDLE, `valid`, `dirty` and `cnt` clear, and `mem_req` drops immediately. Data and tag arrays are not reset.
  - A clean victim is never written back.
  - A write hit to a dirty line leaves `dirty` at 1.

## Timing
- Reset values: `miss=0` (when no request is pending), `rdata=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- Hit: `miss=0` in the same cycle the request is presented. Read data is valid in that cycle. Write data commits at the next edge.
- Clean miss: `miss` stays high for 8 acks plus 1 cycle. It falls in the cycle after the final ack's edge, when `rdata` is valid.
- Dirty miss: 16 acks plus 1 cycle.
- `mem_req` stays high continuously across all 8 words of a phase, and WB→FILL has no bubble. `mem_addr`/`mem_wdata` are stable until `mem_ack`.
- `mem_ack` may arrive no earlier than one cycle after `mem_req` rises.

## Structure
- Package `l1_dcache_pkg`:
  - `TAG_W=23`, `SET_W=4`, `WORD_W=3`.
  - State enum {IDLE, WB, FILL}.
  - An address-split struct {tag, set, word, byte}.
- Sub-module `dcache_line_store`:
  - Holds the valid/dirty/tag/data arrays.
  - One combinational read port indexed by set/word.
  - One synchronous word-write port.
  - Tag/valid install and dirty set/clear ports.
  - Async clear of valid/dirty.

## Test plan
- Cold read of 0x0000_0100 with the bus returning words 0x10..0x17 on each ack: 8 FILL transfers at 0x100..0x11C, then `miss` low and `rdata=0x10`. A following read of 0x0000_0104 hits in 0 cycles with `rdata=0x11`.
- Write 0x3FF to 0x0000_0108 after that line is resident: no `mem_req`, and `dirty[8]=1`. A read of 0x108 then returns 0x3FF.
- Read of 0x0000_0300 (same set 8, tag 1) with set 8 dirty:
  - 8 WB writes to 0x100..0x11C, with 0x3FF on the 0x108 transfer, then 8 FILL reads at 0x300..0x31C.
  - `mem_req` has no gap, and `miss` stays high 17 cycles with a 1-cycle ack latency.
- Write miss of 0x55 to 0x0000_0440 into a clean set 2: refill 0x440..0x45C, then the write lands and a read of 0x440 returns 0x55.
- `reset` driven low after the 3rd FILL ack: `mem_req`=0 in the same cycle. A read of the same address after release misses again and refills from word 0.
- Stress: random mix of reads, writes and addresses against a reference memory model; every read must match the model.
